shift_pipe: RTL and testbench

- Pipelined, parametrised barrel shifter/rotator with a valid/ready stream interface on both sides.
- Successor to the combinational right-shift primitive:
  - adds left shifts and rotates,
  - adds configurable register insertion between mux levels,
  - carries a sideband tag per operation,
  - supports backpressure and flush.
- Sits beside the ALU as the multi-cycle shift unit feeding the writeback arbiter.

---
 rtl/shift_pkg.sv | 40 ++++
 rtl/shift_level.sv | 33 +++
 rtl/shift_pipe.sv | 204 ++++++++++++++++++++
 tb/tb_shift_pipe.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/shift_pkg.sv
// shift_pkg - shared types and helpers for the pipelined shift unit.
//
// Contents:
//   shift_op_t    : operation encoding presented on shift_pipe.in_op
//   calc_latency  : number of pipeline stages (== result latency in cycles)
//   is_left       : op runs through the bit-reversal wrapper
//   is_rotate     : op wraps shifted-out bits back in
//   is_reserved   : op returns its operand unchanged
package shift_pkg;

  typedef enum logic [2:0] {
    OP_SLL  = 3'd0,
    OP_SRL  = 3'd1,
    OP_SRA  = 3'd2,
    OP_ROR  = 3'd3,
    OP_ROL  = 3'd4,
    OP_RSV5 = 3'd5,
    OP_RSV6 = 3'd6,
    OP_RSV7 = 3'd7
  } shift_op_t;

  // One register stage per group of levels_per_reg mux levels, the last
  // group possibly being short.
  function automatic int calc_latency(input int depth, input int levels_per_reg);
    return (depth + levels_per_reg - 1) / levels_per_reg;
  endfunction

  function automatic logic is_left(input shift_op_t op);
    return (op == OP_SLL) || (op == OP_ROL);
  endfunction

  function automatic logic is_rotate(input shift_op_t op);
    return (op == OP_ROR) || (op == OP_ROL);
  endfunction

  function automatic logic is_reserved(input shift_op_t op);
    return (op == OP_RSV5) || (op == OP_RSV6) || (op == OP_RSV7);
  endfunction

endpackage

// File: rtl/shift_level.sv
// shift_level - one combinational mux level of the right-direction shift core.
//
// Ports:
//   din    in  WIDTH  level input
//   en     in  1      shift this level by SHIFT positions
//   rotate in  1      refill vacated bits with the bits shifted out
//   fill   in  1      refill bit for non-rotate shifts
//   dout   out WIDTH  level output
module shift_level #(
  parameter int WIDTH = 32,
  parameter int SHIFT = 1
) (
  input  logic [WIDTH-1:0] din,
  input  logic             en,
  input  logic             rotate,
  input  logic             fill,
  output logic [WIDTH-1:0] dout
);

  // Right shift by SHIFT; the vacated top bits come either from the wrapped
  // low bits (rotate) or from the replicated fill bit.
  always_comb begin
    dout = din;
    if (en) begin
      if (rotate) begin
        dout = {din[SHIFT-1:0], din[WIDTH-1:SHIFT]};
      end else begin
        dout = {{SHIFT{fill}}, din[WIDTH-1:SHIFT]};
      end
    end
  end

endmodule

// File: rtl/shift_pipe.sv
// shift_pipe - pipelined barrel shifter / rotator with valid/ready streams.
//
// Left operations are bit-reversed on entry and exit around a right-direction
// core of DEPTH mux levels. A register stage follows every LEVELS_PER_REG
// levels and the final level, giving calc_latency(DEPTH, LEVELS_PER_REG)
// cycles of latency. Backpressure stalls the whole pipe at once.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   flush                 kill every in-flight operation (and a same-cycle accept)
//   in_valid/in_ready     operation handshake
//   in_data/in_amt/in_op  operand, amount, opcode
//   in_tag                sideband tag carried with the operation
//   out_valid/out_ready   result handshake
//   out_data/out_tag      result and its tag
//   busy                  any pipeline slot occupied
module shift_pipe
  import shift_pkg::*;
#(
  parameter int WIDTH          = 32,
  parameter int DEPTH          = 5,
  parameter int LEVELS_PER_REG = 2,
  parameter int TAG_W          = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [DEPTH-1:0] in_amt,
  input  shift_op_t        in_op,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [TAG_W-1:0] out_tag,
  output logic             busy
);

  localparam int NS = calc_latency(DEPTH, LEVELS_PER_REG);

  if (WIDTH != (1 << DEPTH)) begin : g_bad_width
    $error("shift_pipe: WIDTH must equal 2**DEPTH");
  end
  if (LEVELS_PER_REG < 1 || LEVELS_PER_REG > DEPTH) begin : g_bad_lpr
    $error("shift_pipe: LEVELS_PER_REG must lie in 1..DEPTH");
  end

  // Stage registers; index NS-1 is the output slot.
  logic             st_valid [NS];
  logic [WIDTH-1:0] st_data  [NS];
  logic [DEPTH-1:0] st_amt   [NS];
  shift_op_t        st_op    [NS];
  logic             st_sign  [NS];
  logic [TAG_W-1:0] st_tag   [NS];

  // Inputs feeding each stage's group of levels (entry or previous stage).
  logic             grp_valid [NS];
  logic [WIDTH-1:0] grp_data  [NS];
  logic [DEPTH-1:0] grp_amt   [NS];
  shift_op_t        grp_op    [NS];
  logic             grp_sign  [NS];
  logic [TAG_W-1:0] grp_tag   [NS];

  // Data to be captured by each stage register.
  logic [WIDTH-1:0] nxt_data [NS];

  logic             advance;
  logic             accept;
  logic [WIDTH-1:0] entry_data;
  logic [DEPTH-1:0] entry_amt;
  logic [WIDTH-1:0] last_data;
  logic [WIDTH-1:0] exit_data;

  // The only stall source is a full output slot the consumer is not taking.
  assign advance  = !(st_valid[NS-1] && !out_ready);
  assign in_ready = advance;
  assign accept   = in_valid && in_ready;

  // Entry normalisation: reverse left ops so the core only shifts right, and
  // zero the amount of reserved ops so they pass straight through.
  always_comb begin
    entry_data = in_data;
    if (is_left(in_op)) begin
      for (int b = 0; b < WIDTH; b++) begin
        entry_data[b] = in_data[WIDTH-1-b];
      end
    end
    entry_amt = is_reserved(in_op) ? '0 : in_amt;
  end

  // Mux levels; each level's controls come from the group its stage owns.
  for (genvar j = 0; j < DEPTH; j++) begin : g_level
    localparam int S = j / LEVELS_PER_REG;
    logic [WIDTH-1:0] din;
    logic [WIDTH-1:0] dout;
    logic             en;
    logic             rot;
    logic             fill;

    if (j % LEVELS_PER_REG == 0) begin : g_first
      assign din = grp_data[S];
    end else begin : g_chain
      assign din = g_level[j-1].dout;
    end

    assign en   = grp_amt[S][j];
    assign rot  = is_rotate(grp_op[S]);
    assign fill = (grp_op[S] == OP_SRA) && grp_sign[S];

    shift_level #(
      .WIDTH (WIDTH),
      .SHIFT (1 << j)
    ) u_level (
      .din    (din),
      .en     (en),
      .rotate (rot),
      .fill   (fill),
      .dout   (dout)
    );
  end

  assign last_data = g_level[DEPTH-1].dout;

  // Exit: undo the entry reversal for left ops before the output register.
  always_comb begin
    exit_data = last_data;
    if (is_left(grp_op[NS-1])) begin
      for (int b = 0; b < WIDTH; b++) begin
        exit_data[b] = last_data[WIDTH-1-b];
      end
    end
  end

  // Stage wiring: source of each group and the value its register captures.
  for (genvar s = 0; s < NS; s++) begin : g_stage
    localparam int LAST = ((s + 1) * LEVELS_PER_REG < DEPTH) ?
                          (s + 1) * LEVELS_PER_REG - 1 : DEPTH - 1;

    if (s == 0) begin : g_src_entry
      assign grp_valid[s] = accept;
      assign grp_data[s]  = entry_data;
      assign grp_amt[s]   = entry_amt;
      assign grp_op[s]    = in_op;
      assign grp_sign[s]  = in_data[WIDTH-1];
      assign grp_tag[s]   = in_tag;
    end else begin : g_src_reg
      assign grp_valid[s] = st_valid[s-1];
      assign grp_data[s]  = st_data[s-1];
      assign grp_amt[s]   = st_amt[s-1];
      assign grp_op[s]    = st_op[s-1];
      assign grp_sign[s]  = st_sign[s-1];
      assign grp_tag[s]   = st_tag[s-1];
    end

    if (s == NS - 1) begin : g_cap_exit
      assign nxt_data[s] = exit_data;
    end else begin : g_cap_level
      assign nxt_data[s] = g_level[LAST].dout;
    end
  end

  // Pipeline registers: everything moves together or holds together; flush
  // drops all valids (including a same-cycle accept) but leaves data alone.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int s = 0; s < NS; s++) begin
        st_valid[s] <= 1'b0;
        st_data[s]  <= '0;
        st_amt[s]   <= '0;
        st_op[s]    <= OP_SLL;
        st_sign[s]  <= 1'b0;
        st_tag[s]   <= '0;
      end
    end else if (advance) begin
      for (int s = 0; s < NS; s++) begin
        st_valid[s] <= grp_valid[s] && !flush;
        st_data[s]  <= nxt_data[s];
        st_amt[s]   <= grp_amt[s];
        st_op[s]    <= grp_op[s];
        st_sign[s]  <= grp_sign[s];
        st_tag[s]   <= grp_tag[s];
      end
    end else if (flush) begin
      for (int s = 0; s < NS; s++) begin
        st_valid[s] <= 1'b0;
      end
    end
  end

  // Occupancy summary for the writeback arbiter.
  always_comb begin
    busy = 1'b0;
    for (int s = 0; s < NS; s++) begin
      busy = busy | st_valid[s];
    end
  end

  assign out_valid = st_valid[NS-1];
  assign out_data  = st_data[NS-1];
  assign out_tag   = st_tag[NS-1];

endmodule

// File: tb/tb_shift_pipe.sv
// tb_shift_pipe - scoreboard bench for shift_pipe (WIDTH=32, DEPTH=5,
// LEVELS_PER_REG=2, latency 3). Stimulus pushes hand-computed results into a
// queue; an independent monitor pops and compares on each output transfer.
module tb_shift_pipe;
  import shift_pkg::*;

  localparam int WIDTH = 32;
  localparam int DEPTH = 5;
  localparam int LPR   = 2;
  localparam int TAG_W = 4;
  localparam int LAT   = 3;

  logic             clk;
  logic             rst_n;
  logic             flush;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic [DEPTH-1:0] in_amt;
  shift_op_t        in_op;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic [TAG_W-1:0] out_tag;
  logic             busy;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  typedef struct {
    logic [WIDTH-1:0] data;
    logic [TAG_W-1:0] tag;
    int               acc_cyc;
    bit               chk_lat;
  } exp_t;

  exp_t sb[$];

  typedef struct {
    logic [2:0]  op;
    logic [4:0]  amt;
    logic [31:0] data;
    logic [31:0] exp;
  } vec_t;

  vec_t dir_vecs [16] = '{
    '{3'd2, 5'd4,  32'h80000000, 32'hF8000000},
    '{3'd1, 5'd4,  32'h80000000, 32'h08000000},
    '{3'd4, 5'd1,  32'h80000001, 32'h00000003},
    '{3'd3, 5'd1,  32'h00000001, 32'h80000000},
    '{3'd3, 5'd16, 32'h12345678, 32'h56781234},
    '{3'd0, 5'd31, 32'h00000001, 32'h80000000},
    '{3'd0, 5'd0,  32'hDEADBEEF, 32'hDEADBEEF},
    '{3'd1, 5'd0,  32'hDEADBEEF, 32'hDEADBEEF},
    '{3'd2, 5'd0,  32'hDEADBEEF, 32'hDEADBEEF},
    '{3'd3, 5'd0,  32'hDEADBEEF, 32'hDEADBEEF},
    '{3'd4, 5'd0,  32'hDEADBEEF, 32'hDEADBEEF},
    '{3'd6, 5'd7,  32'h13572468, 32'h13572468},
    '{3'd5, 5'd31, 32'h80000000, 32'h80000000},
    '{3'd0, 5'd4,  32'h0000000F, 32'h000000F0},
    '{3'd2, 5'd31, 32'h80000000, 32'hFFFFFFFF},
    '{3'd2, 5'd3,  32'h40000000, 32'h08000000}
  };

  vec_t stall_vecs [6] = '{
    '{3'd0, 5'd1, 32'h00000001, 32'h00000002},
    '{3'd1, 5'd4, 32'h00000100, 32'h00000010},
    '{3'd2, 5'd8, 32'hF0000000, 32'hFFF00000},
    '{3'd3, 5'd4, 32'h0000000F, 32'hF0000000},
    '{3'd4, 5'd4, 32'hF0000000, 32'h0000000F},
    '{3'd7, 5'd3, 32'hCAFEF00D, 32'hCAFEF00D}
  };

  shift_pipe #(
    .WIDTH          (WIDTH),
    .DEPTH          (DEPTH),
    .LEVELS_PER_REG (LPR),
    .TAG_W          (TAG_W)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_amt    (in_amt),
    .in_op     (in_op),
    .in_tag    (in_tag),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_tag   (out_tag),
    .busy      (busy)
  );

  // Free-running clock and a cycle counter used to time results.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Keeps the run bounded whatever the DUT does.
  initial begin : watchdog
    #200000;
    $display("[TB] FAIL watchdog: got no end of test, required completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [63:0] act,
                             input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
    end
  endtask

  // Presents one op, holds it until accepted, and records the expected result.
  task automatic applyStimulus(input logic [2:0] op, input logic [4:0] amt,
                               input logic [31:0] data, input logic [3:0] tag,
                               input logic [31:0] exp, input bit chk_lat);
    int waited;
    waited   = 0;
    in_valid = 1'b1;
    in_op    = shift_op_t'(op);
    in_amt   = amt;
    in_data  = data;
    in_tag   = tag;
    @(negedge clk);
    while (!in_ready && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    if (!in_ready) begin
      n_checks++;
      n_fail++;
      $display("[TB] FAIL accept_timeout: got in_ready=0 for tag %0h, required 1", tag);
    end else if (!flush) begin
      sb.push_back('{exp, tag, cyc, chk_lat});
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    int n;
    n = 0;
    while (sb.size() != 0 && n < 40) begin
      @(negedge clk);
      n++;
    end
    checkOutput(name, sb.size(), 0);
    @(negedge clk);
    checkOutput({name, "_busy"}, busy, 0);
  endtask

  // Monitor: every output transfer must match the head of the scoreboard.
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n && out_valid && out_ready && !flush) begin
        if (sb.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("[TB] FAIL unexpected_output: got tag %0h data 0x%08h, required no output",
                   out_tag, out_data);
        end else begin
          e = sb.pop_front();
          checkOutput("out_data", out_data, e.data);
          checkOutput("out_tag", out_tag, e.tag);
          if (e.chk_lat) checkOutput("latency", cyc - e.acc_cyc, LAT);
        end
      end
    end
  end

  initial begin : main
    rst_n     = 1'b0;
    flush     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    in_amt    = '0;
    in_op     = OP_SLL;
    in_tag    = '0;
    out_ready = 1'b1;

    // Reset state.
    #1;
    checkOutput("rst_out_valid", out_valid, 0);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_out_data", out_data, 0);
    checkOutput("rst_out_tag", out_tag, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("idle_in_ready", in_ready, 1);

    // Directed vectors streamed back to back, each with exact latency.
    for (int i = 0; i < 16; i++) begin
      applyStimulus(dir_vecs[i].op, dir_vecs[i].amt, dir_vecs[i].data, 4'(i),
                    dir_vecs[i].exp, 1'b1);
    end
    wait_drain("dir_drain");

    // Six ops with a four-cycle consumer stall once results start flowing.
    @(posedge clk);
    #1;
    fork
      begin : stall_drv
        for (int i = 0; i < 6; i++) begin
          applyStimulus(stall_vecs[i].op, stall_vecs[i].amt, stall_vecs[i].data,
                        4'(i), stall_vecs[i].exp, 1'b0);
        end
      end
      begin : stall_ctl
        int n;
        n = 0;
        @(negedge clk);
        while (!out_valid && n < 20) begin
          @(negedge clk);
          n++;
        end
        checkOutput("stall_first_valid", out_valid, 1);
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
          @(negedge clk);
          checkOutput("stall_in_ready", in_ready, 0);
          checkOutput("stall_out_valid", out_valid, 1);
          checkOutput("stall_out_tag", out_tag, 1);
          checkOutput("stall_out_data", out_data, 32'h00000010);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
      end
    join
    wait_drain("stall_drain");

    // Flush with three ops in flight and a fourth accepted alongside it.
    @(posedge clk);
    #1;
    applyStimulus(3'd3, 5'd8, 32'h11111111, 4'hA, 32'h11111111, 1'b0);
    applyStimulus(3'd1, 5'd1, 32'h22222222, 4'hB, 32'h11111111, 1'b0);
    applyStimulus(3'd0, 5'd2, 32'h33333333, 4'hC, 32'hCCCCCCCC, 1'b0);
    in_valid = 1'b1;
    in_op    = OP_SRL;
    in_amt   = 5'd1;
    in_data  = 32'h44444444;
    in_tag   = 4'hD;
    flush    = 1'b1;
    @(negedge clk);
    checkOutput("flush_in_ready", in_ready, 1);
    checkOutput("flush_busy_before", busy, 1);
    sb.delete();
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    flush    = 1'b0;
    checkOutput("flush_out_valid", out_valid, 0);
    checkOutput("flush_busy", busy, 0);
    repeat (8) @(negedge clk);
    @(posedge clk);
    #1;
    applyStimulus(3'd1, 5'd31, 32'hFFFFFFFF, 4'hE, 32'h00000001, 1'b1);
    wait_drain("post_flush_drain");

    // Asynchronous reset between edges with two ops in flight.
    @(posedge clk);
    #1;
    applyStimulus(3'd0, 5'd4, 32'h0000000F, 4'h3, 32'h000000F0, 1'b0);
    applyStimulus(3'd2, 5'd1, 32'h80000000, 4'h4, 32'hC0000000, 1'b0);
    @(posedge clk);
    #2;
    checkOutput("pre_reset_out_valid", out_valid, 1);
    rst_n = 1'b0;
    #1;
    checkOutput("mid_rst_out_valid", out_valid, 0);
    checkOutput("mid_rst_busy", busy, 0);
    checkOutput("mid_rst_out_data", out_data, 0);
    checkOutput("mid_rst_out_tag", out_tag, 0);
    sb.delete();
    @(negedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    applyStimulus(3'd4, 5'd8, 32'h12345678, 4'h7, 32'h34567812, 1'b1);
    wait_drain("post_reset_drain");

    repeat (4) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
